cdc_mcp_tx_arb: RTL and testbench
=================================

Name: cdc_mcp_tx_arb

Overview:
- Transmit side of a multi-channel multi-cycle-path (MCP) clock-domain crossing with acknowledge feedback. Runs entirely in the source clock domain.
- Arbitrates NUM_CH valid/ready producers round-robin and captures the winning word into a held-stable data register. It then flips a request toggle and waits for the receiver's acknowledge toggle, which is asynchronous and synchronised internally, before accepting the next word.
- Replaces the open-loop single-channel toggle crossing wherever back-pressure or several sources are required.

Parameters:
- WIDTH, 8: data bits per channel.
- NUM_CH, 4: number of producer channels; must be ≥1.
- SYNC_STAGES, 2: flip-flop stages on the acknowledge synchroniser; must be ≥2.
- CNT_W, 16: width of the completed-transfer counter.

Ports:
- CLK_I  in  1  source-domain clock.
- RST_NI  in  1  reset; asynchronous assert, active-low.
- DATA_I  in  NUM_CH*WIDTH  packed channel data; channel c occupies bits [c*WIDTH +: WIDTH].
- VALID_I  in  NUM_CH  per-channel valid.
- READY_O  out  NUM_CH  per-channel ready; one-hot or zero.
- MCP_DATA_O  out  WIDTH  held data word for the receiver.
- MCP_CH_O  out  CH_W  channel id of the held word; CH_W = max(1, $clog2(NUM_CH)).
- MCP_TOGGLE_O  out  1  request toggle; flips once per transfer.
- MCP_ACK_I  in  1  receiver acknowledge toggle; asynchronous to CLK_I.
- BUSY_O  out  1  high while a transfer is awaiting acknowledge.
- XFER_CNT_O  out  CNT_W  completed transfers, modulo 2^CNT_W.
- ERR_O  out  1  sticky protocol error.

Behaviour:
- Clock and reset: single clock CLK_I. RST_NI is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, sync stages 0, round-robin pointer last = NUM_CH-1 (so channel 0 has top priority first).
- States: IDLE and WAIT_ACK. ack_s is the output of the last synchroniser stage.
- IDLE:
  - grant g = first c with VALID_I[c]=1, searching last+1, last+2, … modulo NUM_CH.
  - READY_O = onehot(g) combinationally. READY_O = 0 if no VALID_I is high.
  - READY_O never depends on anything except state, VALID_I and last.
- Handshake at edge E0 (VALID_I[g] & READY_O[g]):
  - MCP_DATA_O ← DATA_I[g], MCP_CH_O ← g, last ← g.
  - MCP_TOGGLE_O ← ~MCP_TOGGLE_O, BUSY_O ← 1, state ← WAIT_ACK.
- WAIT_ACK:
  - READY_O = 0.
  - MCP_DATA_O and MCP_CH_O are held constant; this is the MCP stability guarantee.
  - When ack_s == MCP_TOGGLE_O: next edge sets state ← IDLE, BUSY_O ← 0, XFER_CNT_O ← XFER_CNT_O+1 (wraps to 0).
- Latency: an acknowledge edge on MCP_ACK_I before edge Ea is seen in ack_s after edge Ea+SYNC_STAGES-1 and returns the block to IDLE at edge Ea+SYNC_STAGES.
  - With MCP_ACK_I looped back to MCP_TOGGLE_O, one transfer completes every SYNC_STAGES+2 cycles.
- MCP_DATA_O and MCP_CH_O keep their last value in IDLE; they change only on a handshake.
- Protocol error: in IDLE, ack_s != MCP_TOGGLE_O (spurious acknowledge) sets ERR_O ← 1. ERR_O clears only on reset. State is unaffected.
- VALID_I deasserting while not granted is legal. No data is lost, since capture happens only on handshake.
- Simultaneous valids are served strictly round-robin. A channel that holds VALID_I continuously waits at most NUM_CH-1 transfers.
- NUM_CH=1: arbiter degenerates; MCP_CH_O is constant 0.
- Reset mid-transfer:
  - Asynchronous return to reset values; the pending word is dropped.
  - The receiver domain must be reset together with this block so that its acknowledge toggle returns to 0. Otherwise ERR_O flags the mismatch.

Decomposition:
- Package cdc_pkg holds:
  - state enum tx_state_e {IDLE, WAIT_ACK};
  - function ch_w(n) returning max(1, $clog2(n));
  - localparam for minimum SYNC_STAGES.
- Sub-module cdc_sync_bit: a SYNC_STAGES-deep single-bit synchroniser with async active-low reset, reusable by the receiver side.
- The round-robin grant stays inline as a combinational function.

Test Plan:
- Single transfer, loopback (MCP_ACK_I=MCP_TOGGLE_O), SYNC_STAGES=2: VALID_I=0001, DATA_I[0]=8'hA5.
  - READY_O=0001 for one cycle.
  - Next cycle MCP_DATA_O=A5, MCP_CH_O=0, MCP_TOGGLE_O=1, BUSY_O=1.
  - BUSY_O low 3 cycles after the handshake; XFER_CNT_O=1.
- All channels valid continuously, loopback, DATA_I[c]=8'h10+c: MCP_CH_O sequence is 0,1,2,3,0,1 with one transfer every 4 cycles; XFER_CNT_O=6 after 24 cycles.
- Held-off acknowledge (MCP_ACK_I tied 0) after one transfer:
  - BUSY_O stays 1 and READY_O=0 for 100 cycles, with MCP_DATA_O unchanged.
  - Flipping MCP_ACK_I to 1 gives BUSY_O=0 exactly SYNC_STAGES+1 edges later.
- Spurious acknowledge: in IDLE with toggle=0, drive MCP_ACK_I=1 → ERR_O=1 after SYNC_STAGES+1 edges and stays set; RST_NI low → ERR_O=0.
- Reset mid-transfer: assert RST_NI during WAIT_ACK, no clock edge → all outputs 0 immediately; after release the first grant goes to channel 0.
- Counter wrap with CNT_W=4, loopback: 16 transfers → XFER_CNT_O returns to 0 and the 17th transfer gives 1.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the MCP clock-domain-crossing blocks.
// Contents: transmit FSM state enum, channel-id width helper, minimum synchroniser depth.
package cdc_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } tx_state_e;

    localparam int unsigned MIN_SYNC_STAGES = 2;

    // Channel-id width: max(1, clog2(n)), so a single channel still has a 1-bit id.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-stage single-bit synchroniser with asynchronous active-low reset.
// Ports: CLK_I destination clock, RST_NI async reset, D_I asynchronous input,
//        Q_O synchronised output (last stage).
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES = MIN_SYNC_STAGES
) (
    input  logic CLK_I,
    input  logic RST_NI,
    input  logic D_I,
    output logic Q_O
);

    logic [STAGES-1:0] sync_q;

    // Shift chain: stage 0 may go metastable, later stages resolve it.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], D_I};
        end
    end

    assign Q_O = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_mcp_tx_arb.sv
// Transmit side of a multi-channel MCP crossing with toggle acknowledge.
// Arbitrates NUM_CH valid/ready producers round-robin, holds the winning word
// stable on MCP_DATA_O/MCP_CH_O, flips MCP_TOGGLE_O and waits for the
// synchronised MCP_ACK_I to match before accepting the next word.
// Ports: CLK_I, RST_NI (async, active-low); DATA_I/VALID_I/READY_O producer side;
//        MCP_DATA_O/MCP_CH_O/MCP_TOGGLE_O/MCP_ACK_I crossing side;
//        BUSY_O transfer pending, XFER_CNT_O completed transfers, ERR_O sticky spurious-ack flag.
module cdc_mcp_tx_arb
    import cdc_pkg::*;
#(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned SYNC_STAGES = 2,
    parameter  int unsigned CNT_W       = 16,
    localparam int unsigned CH_W        = ch_w(NUM_CH)
) (
    input  logic                    CLK_I,
    input  logic                    RST_NI,
    input  logic [NUM_CH*WIDTH-1:0] DATA_I,
    input  logic [NUM_CH-1:0]       VALID_I,
    output logic [NUM_CH-1:0]       READY_O,
    output logic [WIDTH-1:0]        MCP_DATA_O,
    output logic [CH_W-1:0]         MCP_CH_O,
    output logic                    MCP_TOGGLE_O,
    input  logic                    MCP_ACK_I,
    output logic                    BUSY_O,
    output logic [CNT_W-1:0]        XFER_CNT_O,
    output logic                    ERR_O
);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]  last_q, last_d;
    logic             tog_q, tog_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_s;
    logic [CH_W:0]    pick;
    logic [NUM_CH-1:0] ready_c;

    // Round-robin search starting one past the last winner; returns {found, grant}.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] valid,
                                              input logic [CH_W-1:0]   last);
        logic            found;
        logic [CH_W-1:0] grant;
        logic [CH_W-1:0] cand;
        found = 1'b0;
        grant = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((32'(last) + i) % NUM_CH);
            if (!found && valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
        return {found, grant};
    endfunction

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .CLK_I  (CLK_I),
        .RST_NI (RST_NI),
        .D_I    (MCP_ACK_I),
        .Q_O    (ack_s)
    );

    // Next-state and combinational ready.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        tog_d   = tog_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ready_c = '0;
        pick    = rr_pick(VALID_I, last_q);

        unique case (state_q)
            IDLE: begin
                // Receiver must not toggle ack while nothing is outstanding.
                if (ack_s != tog_q) begin
                    err_d = 1'b1;
                end
                if (pick[CH_W]) begin
                    ready_c[pick[CH_W-1:0]] = 1'b1;
                    data_d  = DATA_I[32'(pick[CH_W-1:0])*WIDTH +: WIDTH];
                    ch_d    = pick[CH_W-1:0];
                    last_d  = pick[CH_W-1:0];
                    tog_d   = ~tog_q;
                    busy_d  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == tog_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= IDLE;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            tog_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            tog_q   <= tog_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign READY_O      = ready_c;
    assign MCP_DATA_O   = data_q;
    assign MCP_CH_O     = ch_q;
    assign MCP_TOGGLE_O = tog_q;
    assign BUSY_O       = busy_q;
    assign XFER_CNT_O   = cnt_q;
    assign ERR_O        = err_q;

endmodule

// File: tb/tb_cdc_mcp_tx_arb.sv
// Self-checking bench for cdc_mcp_tx_arb (WIDTH=8, NUM_CH=4, SYNC_STAGES=2, CNT_W=4).
// Table-driven arbitration vectors plus hand-written multi-cycle sequences;
// a scoreboard queue holds expected {channel, data} per request-toggle flip.
module tb_cdc_mcp_tx_arb;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] d;
        logic [3:0] exp_ready;
        logic [1:0] exp_ch;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] dat;
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic [7:0]  mdata;
    logic [1:0]  mch;
    logic        tog;
    logic        ack;
    logic        busy;
    logic [3:0]  cnt;
    logic        err;

    logic        loop;
    logic        ack_man;
    logic        tog_prev;
    logic        gap_chk;
    int          last_flip;
    int          cyc;
    int          n_chk;
    int          n_fail;
    logic [3:0]  exp_cnt;
    exp_t        sb[$];
    vec_t        vecs[8];

    assign ack = loop ? tog : ack_man;

    cdc_mcp_tx_arb #(
        .WIDTH       (WIDTH),
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK_I        (clk),
        .RST_NI       (rst_n),
        .DATA_I       (dat),
        .VALID_I      (vld),
        .READY_O      (rdy),
        .MCP_DATA_O   (mdata),
        .MCP_CH_O     (mch),
        .MCP_TOGGLE_O (tog),
        .MCP_ACK_I    (ack),
        .BUSY_O       (busy),
        .XFER_CNT_O   (cnt),
        .ERR_O        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] d);
        return {d ^ 8'h03, d ^ 8'h02, d ^ 8'h01, d ^ 8'h00};
    endfunction

    // Scoreboard monitor: every request-toggle flip must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            tog_prev = 1'b0;
        end else if (tog !== tog_prev) begin
            tog_prev = tog;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL xfer_unexpected: got ch %0d data %0h expected none", mch, mdata);
            end else begin
                e = sb.pop_front();
                chk("xfer_ch", 32'(mch), 32'(e.ch));
                chk("xfer_data", 32'(mdata), 32'(e.data));
            end
            if (gap_chk && last_flip >= 0) chk("xfer_gap", 32'(cyc - last_flip), 32'(4));
            last_flip = cyc;
        end
    end

    task automatic wait_idle(input int n);
        for (int k = 0; k < n && busy; k++) begin
            @(posedge clk);
            #1;
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: got busy 1 expected 0 within %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        vld   = '0;
        loop  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
    endtask

    // One arbitrated transfer in loopback; called #1 after a rising edge in IDLE.
    task automatic do_xfer(input logic [3:0] valid, input logic [7:0] d,
                           input logic [3:0] exp_ready, input logic [1:0] exp_ch);
        vld = valid;
        dat = pack(d);
        #1;
        chk("ready_grant", 32'(rdy), 32'(exp_ready));
        if (exp_ready != 4'b0000) begin
            sb.push_back('{exp_ch, d ^ {6'b0, exp_ch}});
            @(posedge clk);
            #1;
            chk("ready_wait", 32'(rdy), 32'(0));
            chk("busy_set", 32'(busy), 32'(1));
            vld = '0;
            wait_idle(20);
            exp_cnt = exp_cnt + 4'd1;
            chk("xfer_cnt", 32'(cnt), 32'(exp_cnt));
        end else begin
            @(posedge clk);
            #1;
            chk("busy_idle", 32'(busy), 32'(0));
            vld = '0;
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        last_flip = -1;
        gap_chk   = 1'b0;
        tog_prev  = 1'b0;
        loop      = 1'b1;
        ack_man   = 1'b0;
        vld       = '0;
        dat       = '0;
        exp_cnt   = '0;
        rst_n     = 1'b0;

        vecs[0] = '{4'b1010, 8'h21, 4'b0010, 2'd1};
        vecs[1] = '{4'b1011, 8'h32, 4'b1000, 2'd3};
        vecs[2] = '{4'b1011, 8'h43, 4'b0001, 2'd0};
        vecs[3] = '{4'b0001, 8'h54, 4'b0001, 2'd0};
        vecs[4] = '{4'b0100, 8'h65, 4'b0100, 2'd2};
        vecs[5] = '{4'b0110, 8'h76, 4'b0010, 2'd1};
        vecs[6] = '{4'b0000, 8'h87, 4'b0000, 2'd0};
        vecs[7] = '{4'b1100, 8'h98, 4'b0100, 2'd2};

        // Reset values
        #1;
        chk("rst_ready", 32'(rdy), 32'(0));
        chk("rst_data", 32'(mdata), 32'(0));
        chk("rst_ch", 32'(mch), 32'(0));
        chk("rst_tog", 32'(tog), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cnt", 32'(cnt), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single transfer, channel 0, data A5
        vld = 4'b0001;
        dat = pack(8'hA5);
        #1;
        chk("single_ready", 32'(rdy), 32'(4'b0001));
        sb.push_back('{2'd0, 8'hA5});
        @(posedge clk);
        #1;
        chk("single_data", 32'(mdata), 32'(8'hA5));
        chk("single_ch", 32'(mch), 32'(0));
        chk("single_tog", 32'(tog), 32'(1));
        chk("single_busy0", 32'(busy), 32'(1));
        chk("single_ready_wait", 32'(rdy), 32'(0));
        vld = '0;
        @(posedge clk);
        #1;
        chk("single_busy1", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
        chk("single_busy2", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
        chk("single_busy3", 32'(busy), 32'(0));
        chk("single_cnt", 32'(cnt), 32'(1));
        exp_cnt = 4'd1;

        // Table-driven round-robin arbitration
        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i].valid, vecs[i].d, vecs[i].exp_ready, vecs[i].exp_ch);
        end

        // All channels valid continuously: 0,1,2,3,0,1, one per 4 cycles
        do_reset();
        vld = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            sb.push_back('{2'(c % 4), 8'h10 + 8'(c % 4)});
        end
        dat = {8'h13, 8'h12, 8'h11, 8'h10};
        gap_chk   = 1'b1;
        last_flip = -1;
        repeat (24) @(posedge clk);
        #1;
        vld = '0;
        gap_chk = 1'b0;
        chk("stream_cnt", 32'(cnt), 32'(6));
        chk("stream_sb_empty", 32'(sb.size()), 32'(0));
        exp_cnt = 4'd6;

        // Held-off acknowledge: data stable and ready low while waiting
        ack_man = 1'b0;
        loop    = 1'b0;
        vld = 4'b0010;
        dat = {8'h00, 8'h00, 8'h5C, 8'h00};
        #1;
        chk("hold_ready", 32'(rdy), 32'(4'b0010));
        sb.push_back('{2'd1, 8'h5C});
        @(posedge clk);
        #1;
        vld = 4'b1111;
        dat = 32'hDEADBEEF;
        for (int k = 0; k < 100; k++) begin
            #1;
            chk("hold_busy", 32'(busy), 32'(1));
            chk("hold_ready0", 32'(rdy), 32'(0));
            chk("hold_data", 32'(mdata), 32'(8'h5C));
            @(posedge clk);
            #1;
        end
        vld     = '0;
        ack_man = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_lat1", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
        chk("ack_lat2", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
        chk("ack_lat3", 32'(busy), 32'(0));
        chk("ack_cnt", 32'(cnt), 32'(7));
        loop = 1'b1;

        // Spurious acknowledge in IDLE
        do_reset();
        @(posedge clk);
        #1;
        loop    = 1'b0;
        ack_man = 1'b1;
        @(posedge clk);
        #1;
        chk("spur_err1", 32'(err), 32'(0));
        @(posedge clk);
        #1;
        chk("spur_err2", 32'(err), 32'(0));
        @(posedge clk);
        #1;
        chk("spur_err3", 32'(err), 32'(1));
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("spur_sticky", 32'(err), 32'(1));
            chk("spur_busy", 32'(busy), 32'(0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("spur_rst_clr", 32'(err), 32'(0));
        loop    = 1'b1;
        ack_man = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;

        // Reset mid-transfer, then first grant to channel 0
        vld = 4'b0100;
        dat = pack(8'h3C);
        #1;
        chk("mid_ready", 32'(rdy), 32'(4'b0100));
        sb.push_back('{2'd2, 8'h3E});
        @(posedge clk);
        #1;
        vld = '0;
        chk("mid_busy", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(mdata), 32'(0));
        chk("mid_rst_ch", 32'(mch), 32'(0));
        chk("mid_rst_tog", 32'(tog), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_cnt", 32'(cnt), 32'(0));
        chk("mid_rst_err", 32'(err), 32'(0));
        chk("mid_rst_ready", 32'(rdy), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_xfer(4'b1111, 8'h70, 4'b0001, 2'd0);

        // Counter wrap at 2^CNT_W
        do_reset();
        for (int k = 0; k < 16; k++) begin
            do_xfer(4'b0001, 8'(8'h80 + k), 4'b0001, 2'd0);
        end
        chk("wrap_16", 32'(cnt), 32'(0));
        do_xfer(4'b0001, 8'hF0, 4'b0001, 2'd0);
        chk("wrap_17", 32'(cnt), 32'(1));

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
